eth_pktgen: RTL and testbench

Parametrised UDP/IPv4 test-frame generator on the 10G MAC transmit path, clocked by `clk156`, driving a 64-bit AXI4-Stream master.
- Builds well-formed Ethernet/IPv4/UDP frames with a valid IP header checksum and runtime-selectable payload length and pattern.
- Supports a programmable inter-frame gap, single-burst or continuous operation, and fully back-pressure-safe AXI-Stream output.
- Used for link bring-up and throughput measurement ahead of the key-value datapath.

---
 rtl/eth_pktgen.sv | 129 ++++++++++++
 tb/tb_eth_pktgen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pktgen.sv
// eth_pktgen: UDP/IPv4 test-frame generator driving a 64-bit AXI4-Stream master.
// Beat data is decoded from registered frame state, so it holds still whenever the sink stalls.
module eth_pktgen #(
    parameter logic [47:0] ETH_DST    = 48'h90E2BA5D8DC9,
    parameter logic [47:0] ETH_SRC    = 48'h001122334455,
    parameter logic [31:0] IP_SADDR   = 32'hC0A80B01,
    parameter logic [31:0] IP_DADDR   = 32'hC0A80B03,
    parameter logic [15:0] UDP_SPORT  = 16'h3776,
    parameter logic [15:0] UDP_DPORT  = 16'h3776,
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter logic [15:0] IFG_CYCLES = 16'd12
) (
    input  logic        clk156,
    input  logic        eth_rst_n,
    input  logic        enable,
    input  logic [15:0] payload_len,
    input  logic        pattern,
    input  logic [15:0] frame_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, HDR = 3'd2, PAYLOAD = 3'd3, GAP = 3'd4;

    logic [2:0] state;
    logic [10:0] len, len_c, flen, flen_c, b;
    logic pat, wait_low, accept, gap_end, burst_end;
    logic [15:0] csum, csum_c, fc, bcnt, gcnt, s2;
    logic [7:0] beat, nbeats, lkeep;
    logic [31:0] s0;
    logic [16:0] s1;
    logic [367:0] hdr;
    logic [45:0][7:0] hb;

    always_comb begin
        len_c = payload_len < 16'd18 ? 11'd18 : payload_len > 16'd1472 ? 11'd1472 : payload_len[10:0];
        flen_c = len_c + 11'd42;
        s0 = 32'h4500 + 32'(len_c) + 32'd28 + 32'(frames_sent[15:0]) + 32'h4000 + 32'({IP_TTL, 8'h11})
           + 32'(IP_SADDR[31:16]) + 32'(IP_SADDR[15:0]) + 32'(IP_DADDR[31:16]) + 32'(IP_DADDR[15:0]);
        s1 = 17'(s0[15:0]) + 17'(s0[31:16]);
        s2 = s1[15:0] + 16'(s1[16]);
        csum_c = ~s2;
    end

    assign flen = len + 11'd42;
    // Header plus the 4-byte frame sequence number that opens the payload, byte 0 in the MSBs
    assign hdr = {ETH_DST, ETH_SRC, 16'h0800, 8'h45, 8'h00, 16'(len) + 16'd28, frames_sent[15:0], 16'h4000,
                  IP_TTL, 8'h11, csum, IP_SADDR, IP_DADDR, UDP_SPORT, UDP_DPORT, 16'(len) + 16'd8, 16'h0000,
                  frames_sent};
    assign hb = hdr;

    assign m_axis_tvalid = state == HDR || state == PAYLOAD;
    assign m_axis_tlast = m_axis_tvalid && beat == nbeats - 8'd1;
    assign m_axis_tkeep = !m_axis_tvalid ? 8'h00 : m_axis_tlast ? lkeep : 8'hFF;
    assign m_axis_tuser = 1'b0;
    assign busy = state != IDLE;
    assign accept = m_axis_tvalid && m_axis_tready;
    assign gap_end = {1'b0, gcnt} + 17'd1 >= {1'b0, IFG_CYCLES};
    assign burst_end = fc != 16'd0 && bcnt == fc;

    always_comb begin
        m_axis_tdata = '0;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            b = {beat, 3'(j)};
            m_axis_tdata[8*j+:8] = !m_axis_tvalid || b >= flen ? 8'h00 :
                                   b < 11'd46 ? hb[6'd45 - b[5:0]] :
                                   pat ? 8'hFF : b[7:0] - 8'd42;
        end
    end

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state <= IDLE;
            len <= 11'd18;
            pat <= 1'b0;
            fc <= '0;
            csum <= '0;
            nbeats <= 8'd1;
            lkeep <= 8'hFF;
            beat <= '0;
            bcnt <= '0;
            gcnt <= '0;
            wait_low <= 1'b0;
            done <= 1'b0;
            frames_sent <= '0;
        end else begin
            done <= 1'b0;
            if (!enable) wait_low <= 1'b0;
            if (accept) beat <= beat + 8'd1;
            if (accept && m_axis_tlast) begin
                frames_sent <= frames_sent + 32'd1;
                bcnt <= bcnt + 16'd1;
            end
            case (state)
                IDLE: if (enable && !wait_low) state <= LOAD;
                LOAD: begin
                    len <= len_c;
                    pat <= pattern;
                    fc <= frame_count;
                    csum <= csum_c;
                    nbeats <= 8'((flen_c + 11'd7) >> 3);
                    lkeep <= flen_c[2:0] == 3'd0 ? 8'hFF : 8'hFF >> (3'd0 - flen_c[2:0]);
                    beat <= '0;
                    state <= HDR;
                end
                HDR: if (accept && beat == 8'd4) state <= PAYLOAD;
                PAYLOAD: if (accept && m_axis_tlast) begin
                    state <= GAP;
                    gcnt <= '0;
                end
                GAP: if (!gap_end) gcnt <= gcnt + 16'd1;
                else if (burst_end || !enable) begin
                    state <= IDLE;
                    bcnt <= '0;
                    done <= burst_end;
                    wait_low <= burst_end;
                end else state <= LOAD;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_pktgen.sv
// tb_eth_pktgen: scoreboard bench for eth_pktgen; a reference model queues every expected
// beat when a burst is started and the monitor pops and compares each accepted beat.
module tb_eth_pktgen;
    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic clk156 = 1'b0, eth_rst_n = 1'b1, enable = 1'b0, pattern = 1'b0, m_axis_tready = 1'b1;
    logic [15:0] payload_len = 16'd18, frame_count = 16'd1;
    logic busy, done, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [31:0] frames_sent;
    logic [63:0] m_axis_tdata;
    logic [7:0] m_axis_tkeep;

    logic [47:0] dst = 48'h90E2BA5D8DC9, src = 48'h001122334455;
    logic [31:0] sip = 32'hC0A80B01, dip = 32'hC0A80B03;
    logic [15:0] port = 16'h3776;

    int n_checks = 0, n_errors = 0;
    beat_t sb[$];
    int fs_model = 0, bif = 0, nfr = 0, ndone = 0, last_nb = 0, idle_run = 0, gap_meas = 0;
    logic [7:0] last_kp = '0;
    logic [63:0] first_d = '0, cap2 = '0, cap3 = '0, pd = '0;
    logic [8:0] pk = '0;
    logic prev_stall = 1'b0, after_last = 1'b0;

    always #5 clk156 = ~clk156;

    eth_pktgen dut (
        .clk156(clk156), .eth_rst_n(eth_rst_n), .enable(enable), .payload_len(payload_len),
        .pattern(pattern), .frame_count(frame_count), .busy(busy), .done(done),
        .frames_sent(frames_sent), .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int len_in, input bit pt, input int fs);
        logic [7:0] fb [0:1519];
        logic [31:0] s;
        logic [31:0] fsv;
        beat_t bt;
        int len, n, nb, idx;
        len = len_in < 18 ? 18 : len_in > 1472 ? 1472 : len_in;
        n = 42 + len;
        fsv = fs;
        for (int i = 0; i < 1520; i++) fb[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            fb[i] = dst[8*(5-i)+:8];
            fb[6+i] = src[8*(5-i)+:8];
        end
        fb[12] = 8'h08;
        fb[14] = 8'h45;
        {fb[16], fb[17]} = 16'(28 + len);
        {fb[18], fb[19]} = fsv[15:0];
        fb[20] = 8'h40;
        fb[22] = 8'd64;
        fb[23] = 8'h11;
        {fb[26], fb[27], fb[28], fb[29]} = sip;
        {fb[30], fb[31], fb[32], fb[33]} = dip;
        {fb[34], fb[35]} = port;
        {fb[36], fb[37]} = port;
        {fb[38], fb[39]} = 16'(8 + len);
        {fb[42], fb[43], fb[44], fb[45]} = fsv;
        for (int k = 4; k < len; k++) fb[42+k] = pt ? 8'hFF : 8'(k);
        s = '0;
        for (int i = 0; i < 10; i++) s += 32'({fb[14+2*i], fb[15+2*i]});
        s = 32'(s[15:0]) + 32'(s[31:16]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        {fb[24], fb[25]} = ~s[15:0];
        nb = (n + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            bt.d = '0;
            bt.k = '0;
            for (int j = 0; j < 8; j++) begin
                idx = 8 * bi + j;
                bt.d[8*j+:8] = fb[idx];
                bt.k[j] = idx < n;
            end
            bt.l = bi == nb - 1;
            sb.push_back(bt);
        end
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        bit ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk156);
            #1;
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            ok = !busy;
        end
        if (!ok) check("timeout_idle", 1, 0);
    endtask

    task automatic run_burst(input int len, input bit pt, input int nfrm, input bit rnd,
                             input int exp_nb, input logic [7:0] exp_kp);
        int done0;
        done0 = ndone;
        for (int i = 0; i < nfrm; i++) begin
            push_frame(len, pt, fs_model);
            fs_model++;
        end
        payload_len = 16'(len);
        pattern = pt;
        frame_count = 16'(nfrm);
        enable = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        wait_idle(20000, rnd);
        enable = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        check("sb_empty", 64'(sb.size()), 0);
        check("frames_sent", frames_sent, 64'(fs_model));
        check("done_pulses", 64'(ndone - done0), 1);
        check("beats", 64'(last_nb), 64'(exp_nb));
        check("last_keep", last_kp, exp_kp);
    endtask

    always @(negedge clk156) begin
        beat_t e;
        logic [63:0] m;
        if (!eth_rst_n) begin
            bif = 0;
            prev_stall = 1'b0;
            after_last = 1'b0;
        end else begin
            if (done) ndone++;
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, pd);
                check("stall_ctl", {m_axis_tkeep, m_axis_tlast}, pk);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pk = {m_axis_tkeep, m_axis_tlast};
            if (m_axis_tvalid) begin
                if (after_last) begin
                    gap_meas = idle_run;
                    after_last = 1'b0;
                end
                if (m_axis_tready) begin
                    if (sb.size() == 0) check("extra_beat", 1, 0);
                    else begin
                        e = sb.pop_front();
                        for (int j = 0; j < 8; j++) m[8*j+:8] = {8{e.k[j]}};
                        check("tdata", m_axis_tdata & m, e.d & m);
                        check("tkeep", m_axis_tkeep, e.k);
                        check("tlast", m_axis_tlast, e.l);
                    end
                    if (bif == 0) first_d = m_axis_tdata;
                    if (bif == 2) cap2 = m_axis_tdata;
                    if (bif == 3) cap3 = m_axis_tdata;
                    bif++;
                    if (m_axis_tlast) begin
                        last_nb = bif;
                        last_kp = m_axis_tkeep;
                        bif = 0;
                        after_last = 1'b1;
                        idle_run = 0;
                        nfr++;
                    end
                end
            end else if (after_last) idle_run++;
        end
    end

    initial begin
        logic [47:0] ed;
        bit hit;
        int nfr0, done0;
        #2 eth_rst_n = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frames", frames_sent, 0);
        repeat (3) @(posedge clk156);
        #1 eth_rst_n = 1'b1;
        @(posedge clk156);
        #1;
        run_burst(18, 1'b0, 1, 1'b0, 8, 8'h0F);
        check("ip_totlen", {cap2[7:0], cap2[15:8]}, 64'h002E);
        check("ip_csum", {cap3[7:0], cap3[15:8]}, 64'hA36A);
        run_burst(22, 1'b0, 1, 1'b0, 8, 8'hFF);
        run_burst(1472, 1'b1, 1, 1'b0, 190, 8'h03);
        run_burst(5, 1'b0, 1, 1'b0, 8, 8'h0F);
        run_burst(2000, 1'b0, 1, 1'b0, 190, 8'h03);

        // Reset in the middle of a frame
        push_frame(100, 1'b0, fs_model);
        payload_len = 16'd100;
        pattern = 1'b0;
        frame_count = 16'd1;
        enable = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk156);
            #1;
            hit = bif == 3;
        end
        if (!hit) check("timeout_beat3", 1, 0);
        eth_rst_n = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_tkeep", m_axis_tkeep, 0);
        check("arst_tlast", m_axis_tlast, 0);
        check("arst_busy", busy, 0);
        check("arst_frames", frames_sent, 0);
        sb.delete();
        fs_model = 0;
        enable = 1'b0;
        @(posedge clk156);
        #1 eth_rst_n = 1'b1;
        @(posedge clk156);
        #1;
        run_burst(100, 1'b0, 1, 1'b0, 18, 8'h3F);
        for (int j = 0; j < 6; j++) ed[8*j+:8] = dst[8*(5-j)+:8];
        check("post_rst_dst", first_d[47:0], ed);
        check("post_rst_id", {cap2[23:16], cap2[31:24]}, 0);

        run_burst(100, 1'b0, 20, 1'b1, 18, 8'h3F);

        // Continuous mode, enable dropped during the third frame
        nfr0 = nfr;
        done0 = ndone;
        for (int i = 0; i < 3; i++) begin
            push_frame(64, 1'b1, fs_model);
            fs_model++;
        end
        payload_len = 16'd64;
        pattern = 1'b1;
        frame_count = 16'd0;
        enable = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge clk156);
            #1;
            hit = nfr >= nfr0 + 2 && bif >= 2;
        end
        if (!hit) check("timeout_third", 1, 0);
        enable = 1'b0;
        wait_idle(2000, 1'b0);
        repeat (2) @(posedge clk156);
        #1;
        check("cont_sb_empty", 64'(sb.size()), 0);
        check("cont_frames", frames_sent, 64'(fs_model));
        check("cont_count", 64'(nfr - nfr0), 3);
        check("cont_no_done", 64'(ndone - done0), 0);
        check("cont_gap", 64'(gap_meas), 13);
        check("cont_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
